ct_rr_arb: RTL and testbench

CT_RR_ARB -- requirements
Module: ct_rr_arb

---
 rtl/ct_rr_arb.sv | 85 ++++++++
 tb/tb_ct_rr_arb.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ct_rr_arb.sv
// ct_rr_arb: packet-aware round-robin arbiter with a registered output stage
module ct_rr_arb #(
  parameter int NI = 4,
  parameter int WIDTH = 32,
  parameter int SELW = $clog2(NI)
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic [NI*WIDTH-1:0] i_data,
  input  logic [NI-1:0]       i_valid,
  input  logic [NI-1:0]       i_eop,
  output logic [NI-1:0]       o_ready,
  output logic [WIDTH-1:0]    o_data,
  output logic                o_valid,
  output logic                o_eop,
  output logic [SELW-1:0]     o_sel,
  input  logic                i_ready
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_nx;
  logic [SELW-1:0] grant, grant_nx, last, last_nx, winner, src;
  logic pipe_en, xfer;
  int k;
  // round-robin search starting after the previous packet's winner; the loop runs backwards so the nearest valid stream is assigned last
  always_comb begin
    winner = '0;
    k = 0;
    for (int i = NI; i >= 1; i--) begin
      k = int'(last) + i;
      if (k >= NI) k = k - NI;
      if (i_valid[k]) winner = SELW'(k);
    end
  end
  assign pipe_en = i_ready | ~o_valid;
  assign src = state == LOCKED ? grant : winner;
  assign xfer = pipe_en & i_valid[src];
  // a locked stream keeps its ready while the output can load, even if its valid drops
  always_comb begin
    o_ready = '0;
    if (arst_n && pipe_en && (state == LOCKED || i_valid[src])) o_ready[src] = 1'b1;
  end
  // packet lock: enter on a non-final beat from IDLE, leave on the locked stream's eop
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    last_nx = last;
    if (xfer && state == IDLE && i_eop[src]) last_nx = src;
    if (xfer && state == IDLE && !i_eop[src]) begin
      state_nx = LOCKED;
      grant_nx = src;
    end
    if (xfer && state == LOCKED && i_eop[src]) begin
      state_nx = IDLE;
      last_nx = src;
    end
  end
  // arbitration state; reset leaves last at NI-1 so stream 0 is searched first
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
      grant <= '0;
      last <= SELW'(NI - 1);
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      last <= last_nx;
    end
  end
  // output register loads when empty or draining; holds otherwise
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      o_valid <= 1'b0;
      o_data <= '0;
      o_eop <= 1'b0;
      o_sel <= '0;
    end else if (pipe_en) begin
      o_valid <= xfer;
      if (xfer) begin
        o_data <= i_data[src*WIDTH +: WIDTH];
        o_eop <= i_eop[src];
        o_sel <= src;
      end
    end
  end
endmodule

// File: tb/tb_ct_rr_arb.sv
// tb_ct_rr_arb: vector table, directed packet scenarios and a random run against a round-robin model
module tb_ct_rr_arb;
  localparam int NI = 4;
  localparam int WIDTH = 32;
  localparam int SELW = 2;
  logic clk, arst_n, o_valid, o_eop, i_ready;
  logic [NI*WIDTH-1:0] i_data;
  logic [NI-1:0] i_valid, i_eop, o_ready;
  logic [WIDTH-1:0] o_data;
  logic [SELW-1:0] o_sel;
  typedef struct {logic [WIDTH-1:0] d; logic eop; int sel;} beat_t;
  typedef struct {logic [NI-1:0] v, e; logic r; logic [NI-1:0] er; logic ov; int sel;} vec_t;
  beat_t q[$];
  vec_t tbl[6];
  int total = 0, bad = 0;
  logic m_lock;
  int m_grant, m_last;
  logic in_pkt;
  int wcnt[NI];
  logic [NI-1:0] s_ready;
  logic s_ov;
  int s_sel;

  ct_rr_arb #(.NI(NI), .WIDTH(WIDTH), .SELW(SELW)) dut (
    .clk(clk), .arst_n(arst_n), .i_data(i_data), .i_valid(i_valid), .i_eop(i_eop),
    .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid), .o_eop(o_eop), .o_sel(o_sel),
    .i_ready(i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, a, x, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_lock = 1'b0;
    m_grant = 0;
    m_last = NI - 1;
    in_pkt = 1'b0;
    for (int s = 0; s < NI; s++) wcnt[s] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst_n = 1'b0;
    i_valid = '1;
    i_eop = '0;
    i_ready = 1'b1;
    #1;
    chk("rst_ovalid", o_valid, 0);
    chk("rst_oready", o_ready, 0);
    chk("rst_odata", o_data, 0);
    chk("rst_osel", o_sel, 0);
    chk("rst_oeop", o_eop, 0);
    model_reset();
    repeat (2) @(negedge clk);
    i_valid = '0;
    arst_n = 1'b1;
  endtask

  task automatic tick(input logic [NI-1:0] v, input logic [NI-1:0] e, input logic r);
    logic [NI-1:0] er, dx;
    logic pe;
    int xk, w, k;
    beat_t b;
    @(negedge clk);
    i_valid = v;
    i_eop = e;
    i_ready = r;
    for (int s = 0; s < NI; s++) i_data[s*WIDTH +: WIDTH] = $urandom;
    #1;
    pe = r || q.size() == 0;
    er = '0;
    if (pe && m_lock) er[m_grant] = 1'b1;
    if (pe && !m_lock)
      for (int j = 1; j <= NI; j++) begin
        k = (m_last + j) % NI;
        if (v[k] && er == 0) er[k] = 1'b1;
      end
    s_ready = o_ready;
    s_ov = o_valid;
    s_sel = int'(o_sel);
    chk("oready", o_ready, er);
    chk("ovalid", o_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("odata", o_data, q[0].d);
      chk("osel", o_sel, q[0].sel);
      chk("oeop", o_eop, q[0].eop);
    end
    dx = s_ready & v;
    if (!in_pkt && dx != 0) begin
      w = 0;
      for (int s = 0; s < NI; s++) if (dx[s]) w = s;
      for (int s = 0; s < NI; s++) begin
        wcnt[s] = (s == w || !v[s]) ? 0 : wcnt[s] + 1;
        chk("fair", wcnt[s] <= NI - 1, 1);
      end
    end
    if (dx != 0) in_pkt = !(|(dx & e));
    xk = -1;
    for (int s = 0; s < NI; s++) if (er[s] && v[s]) xk = s;
    @(posedge clk);
    if (q.size() != 0 && r) void'(q.pop_front());
    if (xk >= 0) begin
      b.d = i_data[xk*WIDTH +: WIDTH];
      b.eop = e[xk];
      b.sel = xk;
      q.push_back(b);
      if (!m_lock && !e[xk]) begin
        m_lock = 1'b1;
        m_grant = xk;
      end else if (e[xk]) begin
        m_lock = 1'b0;
        m_last = xk;
      end
    end
  endtask

  initial begin
    tbl[0] = '{v: 4'b1111, e: 4'b1111, r: 1'b1, er: 4'b0001, ov: 1'b0, sel: 0};
    tbl[1] = '{v: 4'b1111, e: 4'b1111, r: 1'b1, er: 4'b0010, ov: 1'b1, sel: 0};
    tbl[2] = '{v: 4'b1111, e: 4'b1111, r: 1'b1, er: 4'b0100, ov: 1'b1, sel: 1};
    tbl[3] = '{v: 4'b1111, e: 4'b1111, r: 1'b1, er: 4'b1000, ov: 1'b1, sel: 2};
    tbl[4] = '{v: 4'b1111, e: 4'b1111, r: 1'b1, er: 4'b0001, ov: 1'b1, sel: 3};
    tbl[5] = '{v: 4'b1111, e: 4'b1111, r: 1'b1, er: 4'b0010, ov: 1'b1, sel: 0};
    arst_n = 1'b0;
    i_valid = '0;
    i_eop = '0;
    i_ready = 1'b0;
    i_data = '0;
    do_reset();
    for (int t = 0; t < 6; t++) begin
      tick(tbl[t].v, tbl[t].e, tbl[t].r);
      chk("tbl_ready", s_ready, tbl[t].er);
      chk("tbl_ovalid", s_ov, tbl[t].ov);
      if (tbl[t].ov) chk("tbl_sel", s_sel, tbl[t].sel);
    end
    do_reset();
    tick(4'b0100, 4'b0000, 1'b1);
    tick(4'b0101, 4'b0000, 1'b1);
    chk("lock_sel_a", s_sel, 2);
    chk("lock_r0_a", s_ready[0], 0);
    tick(4'b0101, 4'b0100, 1'b1);
    chk("lock_sel_b", s_sel, 2);
    chk("lock_r0_b", s_ready[0], 0);
    tick(4'b0001, 4'b0001, 1'b1);
    chk("lock_sel_c", s_sel, 2);
    tick(4'b0000, 4'b0000, 1'b1);
    chk("lock_sel_d", s_sel, 0);
    do_reset();
    tick(4'b0001, 4'b0001, 1'b1);
    for (int t = 0; t < 5; t++) begin
      tick(4'b0010, 4'b0010, 1'b0);
      chk("stall_ready", s_ready, 0);
      chk("stall_sel", s_sel, 0);
    end
    tick(4'b0010, 4'b0010, 1'b1);
    tick(4'b0000, 4'b0000, 1'b1);
    chk("stall_next", s_sel, 1);
    do_reset();
    tick(4'b0010, 4'b0000, 1'b1);
    tick(4'b1000, 4'b0000, 1'b1);
    chk("drop_r3_a", s_ready, 4'b0010);
    tick(4'b1000, 4'b0000, 1'b1);
    chk("drop_r3_b", s_ready, 4'b0010);
    tick(4'b1010, 4'b0000, 1'b1);
    tick(4'b1010, 4'b0010, 1'b1);
    chk("drop_sel1", s_sel, 1);
    tick(4'b1000, 4'b1000, 1'b1);
    chk("drop_r3_c", s_ready, 4'b1000);
    tick(4'b0000, 4'b0000, 1'b1);
    chk("drop_sel3", s_sel, 3);
    do_reset();
    tick(4'b0010, 4'b0000, 1'b1);
    tick(4'b0010, 4'b0000, 1'b1);
    do_reset();
    tick(4'b1111, 4'b1111, 1'b1);
    chk("rst_first_ready", s_ready, 4'b0001);
    tick(4'b0000, 4'b0000, 1'b1);
    chk("rst_first_sel", s_sel, 0);
    do_reset();
    for (int t = 0; t < 10000; t++)
      tick(NI'($urandom), NI'($urandom & $urandom), ($urandom_range(0, 3) != 0));
    repeat (3) tick('0, '0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
